// File: rtl/piano_mode_scheduler.sv
// piano_mode_scheduler
//   Central controller for the piano note datapath. Holds the play mode
//   (free play, two lessons, two demos) and issues one-cycle start pulses to
//   the autoplay sequencers. It picks which note source drives the tone
//   selector and display. It inserts a short rest between distinct notes.
//   It drops an idle lesson back to free play.
//
// Ports
//   CLK, RESET              clock; asynchronous active-high reset
//   btn_ode / btn_ode_auto  debounced levels: learn / demo Ode to Joy
//   btn_drm / btn_drm_auto  debounced levels: learn / demo Do-Re-Mi
//   QUARTER_BEAT            single-cycle beat tick (drives the idle timeout)
//   free_note/free_valid    switch-decoded note and key-held flag
//   ode_note/ode_valid      Ode autoplay note source
//   ode_done                Ode autoplay finished pulse
//   drm_note/drm_valid      Do-Re-Mi autoplay note source
//   drm_done                Do-Re-Mi autoplay finished pulse
//   mode                    0 FREE, 1 LEARN_ODE, 2 AUTO_ODE, 3 LEARN_DRM, 4 AUTO_DRM
//   ode_start/drm_start     one-cycle start pulses to the sequencers
//   note_out/note_valid     registered, gap-shaped note to tone mux / display
module piano_mode_scheduler #(
  parameter int unsigned GAP_CYCLES = 250000,
  parameter int unsigned GAP_W      = 18,
  parameter int unsigned IDLE_BEATS = 32,
  parameter logic [3:0]  REST       = 4'hF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       btn_ode,
  input  logic       btn_ode_auto,
  input  logic       btn_drm,
  input  logic       btn_drm_auto,
  input  logic       QUARTER_BEAT,
  input  logic [3:0] free_note,
  input  logic       free_valid,
  input  logic [3:0] ode_note,
  input  logic       ode_valid,
  input  logic       ode_done,
  input  logic [3:0] drm_note,
  input  logic       drm_valid,
  input  logic       drm_done,
  output logic [2:0] mode,
  output logic       ode_start,
  output logic       drm_start,
  output logic [3:0] note_out,
  output logic       note_valid
);

  localparam logic [2:0] M_FREE      = 3'd0;
  localparam logic [2:0] M_LEARN_ODE = 3'd1;
  localparam logic [2:0] M_AUTO_ODE  = 3'd2;
  localparam logic [2:0] M_LEARN_DRM = 3'd3;
  localparam logic [2:0] M_AUTO_DRM  = 3'd4;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [8:0]       IDLE_LIM = 9'(IDLE_BEATS);

  logic [2:0]       mode_q, mode_d;
  logic [3:0]       btn_q, btn_d;
  logic [3:0]       btn_now, btn_edge;
  logic [7:0]       idle_q, idle_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       note_out_q, note_out_d;
  logic             note_valid_q, note_valid_d;
  logic             ode_start_q, ode_start_d;
  logic             drm_start_q, drm_start_d;

  logic             learn_mode;
  logic             done_hit;
  logic             idle_expire;
  logic             mode_change;
  logic [3:0]       sel_note;
  logic             sel_valid;
  logic             gap_trigger;

  // Bit order doubles as the edge priority: lowest index wins.
  assign btn_now  = {btn_drm_auto, btn_drm, btn_ode_auto, btn_ode};
  assign btn_edge = btn_now & ~btn_q;

  assign learn_mode = (mode_q == M_LEARN_ODE) || (mode_q == M_LEARN_DRM);
  assign done_hit   = ((mode_q == M_AUTO_ODE) && ode_done) ||
                      ((mode_q == M_AUTO_DRM) && drm_done);
  // Fires on the beat that would bring the count up to the limit, so the
  // mode leaves the lesson on that same edge.
  assign idle_expire = (IDLE_BEATS != 0) && learn_mode && !free_valid &&
                       QUARTER_BEAT && (({1'b0, idle_q} + 9'd1) == IDLE_LIM);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode_q <= M_FREE;
    end else begin
      mode_q <= mode_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    mode_d = mode_q;
    if (btn_edge[0]) begin
      mode_d = (mode_q == M_LEARN_ODE) ? M_FREE : M_LEARN_ODE;
    end else if (btn_edge[1]) begin
      mode_d = (mode_q == M_AUTO_ODE) ? M_FREE : M_AUTO_ODE;
    end else if (btn_edge[2]) begin
      mode_d = (mode_q == M_LEARN_DRM) ? M_FREE : M_LEARN_DRM;
    end else if (btn_edge[3]) begin
      mode_d = (mode_q == M_AUTO_DRM) ? M_FREE : M_AUTO_DRM;
    end else if (done_hit || idle_expire) begin
      mode_d = M_FREE;
    end
  end

  assign mode_change = (mode_d != mode_q);

  // ---------------------------------------------------------------- outputs / datapath
  always_comb begin
    btn_d = btn_now;

    ode_start_d = (mode_d == M_AUTO_ODE) && (mode_q != M_AUTO_ODE);
    drm_start_d = (mode_d == M_AUTO_DRM) && (mode_q != M_AUTO_DRM);

    idle_d = idle_q;
    if (mode_change || !learn_mode || free_valid) begin
      idle_d = 8'd0;
    end else if (QUARTER_BEAT && (idle_q != 8'hFF)) begin
      idle_d = idle_q + 8'd1;
    end

    case (mode_q)
      M_AUTO_ODE: begin
        sel_note  = ode_note;
        sel_valid = ode_valid;
      end
      M_AUTO_DRM: begin
        sel_note  = drm_note;
        sel_valid = drm_valid;
      end
      default: begin
        sel_note  = free_note;
        sel_valid = free_valid;
      end
    endcase

    gap_trigger = mode_change ||
                  (note_valid_q && sel_valid && (sel_note != note_out_q));

    // The trigger edge itself is the first rest cycle; the last count (1)
    // is the edge that resumes the source, giving exactly GAP_CYCLES rests.
    gap_d        = gap_q;
    note_out_d   = REST;
    note_valid_d = 1'b0;
    if ((GAP_CYCLES != 0) && gap_trigger) begin
      gap_d = GAP_LOAD;
    end else if (gap_q > GAP_ONE) begin
      gap_d = gap_q - GAP_ONE;
    end else begin
      gap_d        = '0;
      note_valid_d = sel_valid;
      note_out_d   = sel_valid ? sel_note : REST;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btn_q        <= 4'b1111;  // a button held through reset must be released first
      idle_q       <= 8'd0;
      gap_q        <= '0;
      note_out_q   <= REST;
      note_valid_q <= 1'b0;
      ode_start_q  <= 1'b0;
      drm_start_q  <= 1'b0;
    end else begin
      btn_q        <= btn_d;
      idle_q       <= idle_d;
      gap_q        <= gap_d;
      note_out_q   <= note_out_d;
      note_valid_q <= note_valid_d;
      ode_start_q  <= ode_start_d;
      drm_start_q  <= drm_start_d;
    end
  end

  assign mode       = mode_q;
  assign ode_start  = ode_start_q;
  assign drm_start  = drm_start_q;
  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;

endmodule

// File: tb/tb_piano_mode_scheduler.sv
module tb_piano_mode_scheduler;

  localparam int         GAP  = 4;
  localparam int         IDLE = 3;
  localparam logic [3:0] REST = 4'hF;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       btn_ode, btn_ode_auto, btn_drm, btn_drm_auto;
  logic       QUARTER_BEAT;
  logic [3:0] free_note, ode_note, drm_note;
  logic       free_valid, ode_valid, drm_valid, ode_done, drm_done;
  logic [2:0] mode;
  logic       ode_start, drm_start;
  logic [3:0] note_out;
  logic       note_valid;

  int checks = 0;
  int errors = 0;

  piano_mode_scheduler #(
    .GAP_CYCLES(GAP), .GAP_W(4), .IDLE_BEATS(IDLE), .REST(REST)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .btn_ode(btn_ode), .btn_ode_auto(btn_ode_auto),
    .btn_drm(btn_drm), .btn_drm_auto(btn_drm_auto),
    .QUARTER_BEAT(QUARTER_BEAT),
    .free_note(free_note), .free_valid(free_valid),
    .ode_note(ode_note), .ode_valid(ode_valid), .ode_done(ode_done),
    .drm_note(drm_note), .drm_valid(drm_valid), .drm_done(drm_done),
    .mode(mode), .ode_start(ode_start), .drm_start(drm_start),
    .note_out(note_out), .note_valid(note_valid)
  );

  always #5 CLK = ~CLK;

  // ------------------------------------------------------------ reference model
  // Behavioural view: mode as an integer, "rests still owed" as a count.
  int         m_mode, m_idle, m_rest;
  logic [3:0] m_note;
  bit         m_valid, m_ostart, m_dstart;
  bit         m_hist[4];

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_rest = 0; m_note = REST;
    m_valid = 0; m_ostart = 0; m_dstart = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 1;
  endtask

  task automatic model_step();
    bit         now[4];
    int         nm;
    bit         hit, learn, sv, trig;
    logic [3:0] sn;
    now[0] = btn_ode; now[1] = btn_ode_auto; now[2] = btn_drm; now[3] = btn_drm_auto;
    nm = m_mode; hit = 0;
    for (int i = 0; i < 4; i++)
      if (!hit && now[i] && !m_hist[i]) begin
        hit = 1;
        nm  = (m_mode == i + 1) ? 0 : i + 1;
      end
    learn = (m_mode == 1) || (m_mode == 3);
    if (!hit) begin
      if ((m_mode == 2 && ode_done) || (m_mode == 4 && drm_done)) nm = 0;
      else if (learn && !free_valid && QUARTER_BEAT && m_idle + 1 == IDLE) nm = 0;
    end
    if (m_mode == 2)      begin sn = ode_note;  sv = ode_valid;  end
    else if (m_mode == 4) begin sn = drm_note;  sv = drm_valid;  end
    else                  begin sn = free_note; sv = free_valid; end
    trig = (nm != m_mode) || (m_valid && sv && sn != m_note);
    if (GAP > 0 && trig)  begin m_rest = GAP - 1; m_note = REST; m_valid = 0; end
    else if (m_rest > 0)  begin m_rest--;         m_note = REST; m_valid = 0; end
    else                  begin m_valid = sv; m_note = sv ? sn : REST; end
    if (nm != m_mode || !learn || free_valid) m_idle = 0;
    else if (QUARTER_BEAT && m_idle < 255) m_idle++;
    m_ostart = (nm == 2) && (m_mode != 2);
    m_dstart = (nm == 4) && (m_mode != 4);
    for (int i = 0; i < 4; i++) m_hist[i] = now[i];
    m_mode = nm;
  endtask

  // Advance one clock; inputs set before the call are what the edge sees.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    btn_ode = 0; btn_ode_auto = 0; btn_drm = 0; btn_drm_auto = 0;
    QUARTER_BEAT = 0; free_note = 0; free_valid = 0;
    ode_note = 0; ode_valid = 0; ode_done = 0;
    drm_note = 0; drm_valid = 0; drm_done = 0;
  endtask

  task automatic do_reset();
    RESET = 1; model_reset();
    @(posedge CLK); #1;
    RESET = 0;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    drive_idle();
    RESET = 1; model_reset();
    #3;
    checks += 5;
    if (mode !== 3'd0)     begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
    if (note_out !== REST) begin errors++; $display("FAIL reset_note got %h want %h", note_out, REST); end
    if (note_valid !== 0)  begin errors++; $display("FAIL reset_valid got %b want 0", note_valid); end
    if (ode_start !== 0)   begin errors++; $display("FAIL reset_ode_start got %b want 0", ode_start); end
    if (drm_start !== 0)   begin errors++; $display("FAIL reset_drm_start got %b want 0", drm_start); end
    @(posedge CLK); #1; RESET = 0;
    $display("test_reset done");
  endtask

  task automatic test_free_gap();
    free_valid = 1; free_note = 4'd2; tick();
    checks += 2;
    if (note_out !== 4'd2) begin errors++; $display("FAIL free_first_note got %h want 2", note_out); end
    if (note_valid !== 1)  begin errors++; $display("FAIL free_first_valid got %b want 1", note_valid); end
    free_note = 4'd5;
    for (int i = 0; i < GAP; i++) begin
      tick();
      checks += 2;
      if (note_out !== REST) begin errors++; $display("FAIL gap_note[%0d] got %h want %h", i, note_out, REST); end
      if (note_valid !== 0)  begin errors++; $display("FAIL gap_valid[%0d] got %b want 0", i, note_valid); end
    end
    tick();
    checks += 2;
    if (note_out !== 4'd5) begin errors++; $display("FAIL after_gap_note got %h want 5", note_out); end
    if (note_valid !== 1)  begin errors++; $display("FAIL after_gap_valid got %b want 1", note_valid); end
    // valid->invalid->valid carries no gap even with a new note
    free_valid = 0; tick();
    checks++;
    if (note_out !== REST || note_valid !== 0) begin errors++; $display("FAIL release got %h/%b want %h/0", note_out, note_valid, REST); end
    free_valid = 1; free_note = 4'd9; tick();
    checks++;
    if (note_out !== 4'd9 || note_valid !== 1) begin errors++; $display("FAIL repress got %h/%b want 9/1", note_out, note_valid); end
    $display("test_free_gap done");
  endtask

  task automatic test_auto_ode();
    free_valid = 0;
    ode_done = 1; tick(); ode_done = 0;  // done outside AUTO_ODE is ignored
    checks++;
    if (mode !== 3'd0) begin errors++; $display("FAIL stray_done_mode got %0d want 0", mode); end
    btn_ode_auto = 1; tick();
    checks += 3;
    if (mode !== 3'd2)   begin errors++; $display("FAIL auto_ode_mode got %0d want 2", mode); end
    if (ode_start !== 1) begin errors++; $display("FAIL auto_ode_start got %b want 1", ode_start); end
    if (drm_start !== 0) begin errors++; $display("FAIL auto_ode_drm_start got %b want 0", drm_start); end
    btn_ode_auto = 0; ode_valid = 1; ode_note = 4'd7; tick();
    checks++;
    if (ode_start !== 0) begin errors++; $display("FAIL auto_ode_start_len got %b want 0", ode_start); end
    tick(); tick();
    checks++;
    if (note_valid !== 0) begin errors++; $display("FAIL auto_ode_gap got %b want 0", note_valid); end
    tick();
    checks++;
    if (note_out !== 4'd7 || note_valid !== 1) begin errors++; $display("FAIL auto_ode_note got %h/%b want 7/1", note_out, note_valid); end
    free_valid = 1; free_note = 4'd3; ode_done = 1; tick(); ode_done = 0;
    checks++;
    if (mode !== 3'd0) begin errors++; $display("FAIL ode_done_mode got %0d want 0", mode); end
    for (int i = 0; i < GAP; i++) tick();
    checks++;
    if (note_out !== 4'd3 || note_valid !== 1) begin errors++; $display("FAIL back_to_free got %h/%b want 3/1", note_out, note_valid); end
    $display("test_auto_ode done");
  endtask

  task automatic test_simultaneous_edges();
    free_valid = 0;
    btn_ode = 1; btn_drm = 1; tick();
    checks++;
    if (mode !== 3'd1) begin errors++; $display("FAIL simul_mode got %0d want 1", mode); end
    btn_ode = 0; btn_drm = 0; tick();
    btn_ode = 1; tick();
    checks++;
    if (mode !== 3'd0) begin errors++; $display("FAIL toggle_mode got %0d want 0", mode); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (mode !== 3'd0) begin errors++; $display("FAIL held_mode[%0d] got %0d want 0", i, mode); end
    end
    btn_ode = 0; tick();
    $display("test_simultaneous_edges done");
  endtask

  task automatic test_idle_timeout();
    free_valid = 0;
    btn_drm = 1; tick(); btn_drm = 0; tick();
    checks++;
    if (mode !== 3'd3) begin errors++; $display("FAIL learn_drm_mode got %0d want 3", mode); end
    for (int b = 1; b <= 3; b++) begin
      QUARTER_BEAT = 1; tick(); QUARTER_BEAT = 0;
      checks++;
      if (mode !== ((b < 3) ? 3'd3 : 3'd0)) begin errors++; $display("FAIL idle_beat%0d got %0d want %0d", b, mode, (b < 3) ? 3 : 0); end
      tick();
    end
    btn_drm = 1; tick(); btn_drm = 0; tick();
    for (int b = 1; b <= 2; b++) begin QUARTER_BEAT = 1; tick(); QUARTER_BEAT = 0; tick(); end
    free_valid = 1; tick(); free_valid = 0; tick();
    for (int b = 1; b <= 3; b++) begin
      QUARTER_BEAT = 1; tick(); QUARTER_BEAT = 0;
      checks++;
      if (mode !== ((b < 3) ? 3'd3 : 3'd0)) begin errors++; $display("FAIL idle_after_key%0d got %0d want %0d", b, mode, (b < 3) ? 3 : 0); end
      tick();
    end
    $display("test_idle_timeout done");
  endtask

  task automatic test_done_vs_button();
    btn_drm_auto = 1; tick(); btn_drm_auto = 0;
    checks += 2;
    if (mode !== 3'd4)   begin errors++; $display("FAIL auto_drm_mode got %0d want 4", mode); end
    if (drm_start !== 1) begin errors++; $display("FAIL auto_drm_start got %b want 1", drm_start); end
    tick();
    drm_done = 1; btn_ode = 1; tick(); drm_done = 0; btn_ode = 0;
    checks += 3;
    if (mode !== 3'd1)    begin errors++; $display("FAIL done_vs_btn_mode got %0d want 1", mode); end
    if (drm_start !== 0)  begin errors++; $display("FAIL done_vs_btn_drm_start got %b want 0", drm_start); end
    if (note_valid !== 0) begin errors++; $display("FAIL done_vs_btn_gap got %b want 0", note_valid); end
    tick();
    RESET = 1; model_reset(); #1;
    checks += 3;
    if (mode !== 3'd0)     begin errors++; $display("FAIL midgap_reset_mode got %0d want 0", mode); end
    if (note_out !== REST) begin errors++; $display("FAIL midgap_reset_note got %h want %h", note_out, REST); end
    if (note_valid !== 0)  begin errors++; $display("FAIL midgap_reset_valid got %b want 0", note_valid); end
    @(posedge CLK); #1; RESET = 0;
    $display("test_done_vs_button done");
  endtask

  task automatic test_held_through_reset();
    free_valid = 1; free_note = 4'd6; tick(); tick();
    btn_drm = 1;
    RESET = 1; model_reset(); #1;
    checks++;
    if (note_out !== REST || note_valid !== 0) begin errors++; $display("FAIL async_reset_note got %h/%b want %h/0", note_out, note_valid, REST); end
    @(posedge CLK); #1; RESET = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mode !== 3'd0) begin errors++; $display("FAIL held_reset_mode[%0d] got %0d want 0", i, mode); end
    end
    btn_drm = 0; tick();
    btn_drm = 1; tick(); btn_drm = 0;
    checks++;
    if (mode !== 3'd3) begin errors++; $display("FAIL repress_mode got %0d want 3", mode); end
    tick();
    btn_ode_auto = 1; tick(); btn_ode_auto = 0; tick();
    btn_drm_auto = 1; tick(); btn_drm_auto = 0;
    checks += 3;
    if (mode !== 3'd4)   begin errors++; $display("FAIL demo_switch_mode got %0d want 4", mode); end
    if (drm_start !== 1) begin errors++; $display("FAIL demo_switch_drm_start got %b want 1", drm_start); end
    if (ode_start !== 0) begin errors++; $display("FAIL demo_switch_ode_start got %b want 0", ode_start); end
    tick();
    $display("test_held_through_reset done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) btn_ode      = ~btn_ode;
      if ($urandom_range(15) == 0) btn_ode_auto = ~btn_ode_auto;
      if ($urandom_range(15) == 0) btn_drm      = ~btn_drm;
      if ($urandom_range(15) == 0) btn_drm_auto = ~btn_drm_auto;
      QUARTER_BEAT = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) free_valid = ~free_valid;
      if ($urandom_range(5) == 0) free_note  = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) ode_valid  = ~ode_valid;
      if ($urandom_range(5) == 0) ode_note   = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) drm_valid  = ~drm_valid;
      if ($urandom_range(5) == 0) drm_note   = 4'($urandom_range(15));
      ode_done = ($urandom_range(29) == 0);
      drm_done = ($urandom_range(29) == 0);
      if ($urandom_range(599) == 0) do_reset();
      else tick();
      checks += 5;
      if (mode !== 3'(m_mode))  begin errors++; $display("FAIL rand_mode cyc %0d got %0d want %0d", c, mode, m_mode); end
      if (note_out !== m_note)  begin errors++; $display("FAIL rand_note cyc %0d got %h want %h", c, note_out, m_note); end
      if (note_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, note_valid, m_valid); end
      if (ode_start !== m_ostart) begin errors++; $display("FAIL rand_ode_start cyc %0d got %b want %b", c, ode_start, m_ostart); end
      if (drm_start !== m_dstart) begin errors++; $display("FAIL rand_drm_start cyc %0d got %b want %b", c, drm_start, m_dstart); end
      if (c % 500 == 499) $display("test_random cycle %0d mode %0d", c + 1, mode);
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_free_gap();
    test_auto_ode();
    test_simultaneous_edges();
    test_idle_timeout();
    test_done_vs_button();
    test_held_through_reset();
    drive_idle();
    tick();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piano_mode_scheduler.md
Name: piano_mode_scheduler

Overview:
- Central controller for the piano note datapath.
- Owns the play-mode register (free play, two lessons, two demos) and starts/stops the autoplay sequencers.
- Arbitrates which note source drives the tone selector and display.
- Inserts a short articulation rest between consecutive distinct notes, and returns lesson modes to free play after a configurable idle period.

Parameters:
GAP_CYCLES, 250000, rest length in CLK cycles inserted between distinct notes; 0 disables gaps
GAP_W, 18, gap counter width; must hold GAP_CYCLES
IDLE_BEATS, 32, QUARTER_BEAT ticks with no key in a lesson mode before reverting to free play; 0 disables
REST, 4'hF, note code meaning silence

Ports:
CLK  in  1  system clock
RESET  in  1  reset
btn_ode  in  1  debounced, synchronous level: learn Ode to Joy
btn_ode_auto  in  1  debounced level: Ode to Joy demo
btn_drm  in  1  debounced level: learn Do-Re-Mi
btn_drm_auto  in  1  debounced level: Do-Re-Mi demo
QUARTER_BEAT  in  1  single-cycle beat tick
free_note  in  4  note decoded from switches
free_valid  in  1  a switch key is held
ode_note  in  4  Ode autoplay note
ode_valid  in  1  Ode autoplay note is sounding
ode_done  in  1  one-cycle pulse: Ode autoplay finished
drm_note  in  4  Do-Re-Mi autoplay note
drm_valid  in  1  Do-Re-Mi autoplay note is sounding
drm_done  in  1  one-cycle pulse: Do-Re-Mi autoplay finished
mode  out  3  0 FREE, 1 LEARN_ODE, 2 AUTO_ODE, 3 LEARN_DRM, 4 AUTO_DRM
ode_start  out  1  one-cycle start pulse to the Ode autoplay sequencer
drm_start  out  1  one-cycle start pulse to the Do-Re-Mi autoplay sequencer
note_out  out  4  arbitrated note to the tone mux and display
note_valid  out  1  note_out should sound

Behaviour:
- Reset and clocking:
  - RESET is asynchronous, active-high; all state is clocked on posedge CLK.
  - Reset values: mode=0, ode_start=0, drm_start=0, note_out=REST, note_valid=0, gap counter=0, idle counter=0.
  - Button history registers reset to 1, so a button held through reset must be released before it acts.
- Button edges:
  - edge_x = btn_x & ~btn_x_q (combinational).
  - The mode updates on the same clock edge at which btn_x_q captures the 1.
- Mode transitions:
  - Simultaneous edges: priority ode > ode_auto > drm > drm_auto; the others are dropped.
  - Edge for a mode other than the current one: enter that mode.
  - Edge for the current mode: return to FREE (toggle).
  - Entering AUTO_ODE or AUTO_DRM (including re-entry from the other demo) asserts ode_start or drm_start for exactly one cycle, registered with the mode change.
- Demo completion:
  - ode_done in AUTO_ODE, or drm_done in AUTO_DRM, sets mode to FREE on the next edge.
  - A done pulse in any other mode is ignored.
  - A button edge in the same cycle as done wins.
- Idle timeout:
  - The idle counter (8 bit) increments on QUARTER_BEAT only in LEARN modes while free_valid=0.
  - It clears on free_valid=1, on any mode change, and in non-learn modes.
  - When it reaches IDLE_BEATS, mode becomes FREE on the same edge.
  - Button edges take precedence over the timeout.
- Source select:
  - FREE, LEARN_ODE and LEARN_DRM use free_note/free_valid.
  - AUTO_ODE uses ode_note/ode_valid; AUTO_DRM uses drm_note/drm_valid.
- Output path (registered, 1-cycle latency from the selected source):
  - Gap trigger: a mode change, or (note_valid=1 and sel_valid=1 and sel_note != note_out).
  - On a trigger: load the gap counter with GAP_CYCLES, drive note_valid=0 and note_out=REST.
  - While the counter is non-zero: decrement each cycle and hold REST/0. Source changes during a gap neither restart nor extend it.
  - After the counter reaches 0: follow the selected source (note_out=sel_note, note_valid=sel_valid). If sel_valid=0, note_out=REST.
  - valid->invalid and invalid->valid transitions have no gap.
  - With GAP_CYCLES=0, the trigger has no effect: pure 1-cycle pass-through.
- Reset mid-gap or mid-demo: all state returns to reset values immediately; no start pulse is issued.

Test Plan:
- GAP_CYCLES=4: reset, free_valid=1, free_note=2 -> note_out=2, valid=1 one cycle later. Change to 5 -> 4 cycles of REST/valid=0, then 5/1.
- Rising btn_ode_auto -> mode=2, ode_start high exactly 1 cycle. Then ode_valid=1, ode_note=7 -> note_out=7. ode_done pulse -> mode=0 next cycle, output follows free_note.
- btn_ode and btn_drm rise in the same cycle -> mode=1 only. A second btn_ode rising edge -> mode=0. Holding btn_ode high -> no further transitions.
- IDLE_BEATS=3, mode=3, free_valid=0: 3 QUARTER_BEAT pulses -> mode=0 on the third. A key press after 2 beats clears the count; 3 more beats are then required.
- In AUTO_DRM, drm_done and a btn_ode edge in the same cycle -> mode=1, drm_start stays 0. Assert RESET mid-gap -> note_out=REST, valid=0, mode=0 asynchronously.
- Hold btn_drm through reset release -> no mode change until released and pressed again. Then from AUTO_ODE press btn_drm_auto -> mode=4 with a drm_start pulse.
